// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Frame handshake between the response/command logic (master) and the UART transmitter (slave).
interface uart_tx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_p_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  modport master (
    output i_p_data, i_data_valid, i_par_en, i_par_typ,
    input  o_tx_out, o_busy
  );

  modport slave (
    input  i_p_data, i_data_valid, i_par_en, i_par_typ,
    output o_tx_out, o_busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shadow register plus bit counter; sel_bit is the bit that will be on the line
// after the coming edge, so the top can register it straight onto o_tx_out.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clr,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  sel_bit,
  output logic                  done,
  output logic                  data_xor
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shadow;
  logic [CW-1:0]         cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load || clr) cnt_nxt = '0;
    else if (step)   cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else begin
      if (load) shadow <= data;
      cnt <= cnt_nxt;
    end
  end

  assign sel_bit  = shadow[cnt_nxt];
  assign done     = (cnt == CW'(DATA_WIDTH - 1));
  assign data_xor = ^shadow;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit; one i_clk per bit.
// Line and busy values are computed for the next state and registered, so outputs never glitch.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_fsm_if.slave  bus
);
  tx_state_e state, state_nxt;
  logic      par_en_q, par_typ_q, par_bit;
  logic      load, clr, step, done, sel_bit, data_xor;
  logic      tx_d, busy_d, tx_q, busy_q;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (load),
    .clr      (clr),
    .step     (step),
    .data     (bus.i_p_data),
    .sel_bit  (sel_bit),
    .done     (done),
    .data_xor (data_xor)
  );

  assign par_bit = (par_typ_q == PAR_ODD) ? ~data_xor : data_xor;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clr       = 1'b0;
    step      = 1'b0;
    tx_d      = IDLE_BIT;
    busy_d    = 1'b1;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.i_data_valid) begin
          load      = 1'b1;
          state_nxt = START;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
        end
      end
      START: begin
        clr       = 1'b1;
        state_nxt = DATA;
        tx_d      = sel_bit;
      end
      DATA: begin
        if (done) begin
          clr = 1'b1;
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_d      = par_bit;
          end else begin
            state_nxt = STOP;
            tx_d      = STOP_BIT;
          end
        end else begin
          step = 1'b1;
          tx_d = sel_bit;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        tx_d      = STOP_BIT;
      end
      STOP: begin
        state_nxt = IDLE;
        tx_d      = IDLE_BIT;
        busy_d    = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        tx_d      = IDLE_BIT;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= IDLE_BIT;
      busy_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_q   <= tx_d;
      busy_q <= busy_d;
      if (load) begin
        par_en_q  <= bus.i_par_en;
        par_typ_q <= bus.i_par_typ;
      end
    end
  end

  assign bus.o_tx_out = tx_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed and random frames through uart_tx_fsm clocked by a divide-by-4 of a reference clock;
// every line cycle is compared against a frame built from the UART framing rules.
module tb_uart_tx_fsm;
  localparam int DW = 8;

  logic ref_clk = 1'b0;
  logic i_clk   = 1'b0;
  logic i_rst;
  logic [1:0] div_cnt = '0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  time t_pos = 0;

  uart_tx_fsm_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) begin
    if (div_cnt == 2'd1) begin
      div_cnt <= '0;
      i_clk   <= ~i_clk;
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line may only move on an i_clk rising edge (or asynchronously under reset).
  always @(posedge i_clk) t_pos = $time;
  always @(bus.o_tx_out) if (mon_en && !i_rst) chk("glitch", 32'($time - t_pos), 32'd0);

  function automatic void build_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                                      ref bit q[$]);
    q = {};
    q.push_back(1'b0);
    for (int k = 0; k < DW; k++) q.push_back(bit'((d >> k) & 1));
    if (pen) q.push_back(bit'(($countones(d) % 2) ^ ptyp));
    q.push_back(1'b1);
  endfunction

  // Drives a frame at a falling edge, then checks every line cycle plus the trailing idle cycle.
  // mut_at >= 0 scrambles all frame inputs at that bit index.
  task automatic run_frame(input string tag, input logic [DW-1:0] d, input bit pen,
                           input bit ptyp, input int mut_at);
    bit q[$];
    build_frame(d, pen, ptyp, q);
    @(negedge i_clk);
    bus.i_p_data = d; bus.i_par_en = pen; bus.i_par_typ = ptyp; bus.i_data_valid = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge i_clk);
      if (i == 0) bus.i_data_valid = 1'b0;
      if (i == mut_at) begin
        bus.i_p_data = 8'hFF; bus.i_par_en = ~pen; bus.i_par_typ = ~ptyp;
        bus.i_data_valid = 1'b1;
      end
      chk($sformatf("%s_bit%0d", tag, i), 32'(bus.o_tx_out), 32'(q[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(bus.o_busy), 32'd1);
    end
    bus.i_data_valid = 1'b0;
    @(negedge i_clk);
    chk({tag, "_idle_tx"}, 32'(bus.o_tx_out), 32'd1);
    chk({tag, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit q1[$], q2[$];
    i_rst = 1'b1;
    bus.i_p_data = '0; bus.i_data_valid = 1'b0; bus.i_par_en = 1'b0; bus.i_par_typ = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_tx", 32'(bus.o_tx_out), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    i_rst = 1'b0;
    mon_en = 1;
    @(negedge i_clk);
    chk("post_rst_tx", 32'(bus.o_tx_out), 32'd1);

    // Reset while data bit 3 is on the line.
    build_frame(8'h3C, 1'b1, 1'b0, q1);
    bus.i_p_data = 8'h3C; bus.i_par_en = 1'b1; bus.i_par_typ = 1'b0; bus.i_data_valid = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge i_clk);
      bus.i_data_valid = 1'b0;
      chk($sformatf("pre_rst_bit%0d", i), 32'(bus.o_tx_out), 32'(q1[i]));
    end
    i_rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(bus.o_tx_out), 32'd1);
    chk("async_rst_busy", 32'(bus.o_busy), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_frame("after_rst", 8'h0F, 1'b0, 1'b0, -1);

    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, -1);
    run_frame("07_even", 8'h07, 1'b1, 1'b0, -1);
    run_frame("07_odd", 8'h07, 1'b1, 1'b1, -1);
    run_frame("mut_data", 8'h5A, 1'b1, 1'b1, 3);
    run_frame("mut_nopar", 8'h81, 1'b0, 1'b0, 6);

    // Back-to-back with valid held high: exactly one idle cycle between frames.
    build_frame(8'h55, 1'b0, 1'b0, q1);
    build_frame(8'h33, 1'b0, 1'b0, q2);
    @(negedge i_clk);
    bus.i_p_data = 8'h55; bus.i_par_en = 1'b0; bus.i_par_typ = 1'b0; bus.i_data_valid = 1'b1;
    for (int i = 0; i < q1.size(); i++) begin
      @(negedge i_clk);
      if (i == 0) bus.i_p_data = 8'h33;
      chk($sformatf("b2b1_bit%0d", i), 32'(bus.o_tx_out), 32'(q1[i]));
      chk($sformatf("b2b1_busy%0d", i), 32'(bus.o_busy), 32'd1);
    end
    @(negedge i_clk);
    chk("b2b_gap_tx", 32'(bus.o_tx_out), 32'd1);
    chk("b2b_gap_busy", 32'(bus.o_busy), 32'd0);
    for (int i = 0; i < q2.size(); i++) begin
      @(negedge i_clk);
      if (i == 0) bus.i_data_valid = 1'b0;
      chk($sformatf("b2b2_bit%0d", i), 32'(bus.o_tx_out), 32'(q2[i]));
      chk($sformatf("b2b2_busy%0d", i), 32'(bus.o_busy), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk($sformatf("b2b_tail_tx%0d", i), 32'(bus.o_tx_out), 32'd1);
      chk($sformatf("b2b_tail_busy%0d", i), 32'(bus.o_busy), 32'd0);
    end

    for (int n = 0; n < 24; n++) begin
      run_frame($sformatf("rnd%0d", n), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
